// File: rtl/axi_bram_bank_sequencer_pkg.sv
// Shared command codes, status codes and FSM state types for the BRAM bank sequencer.
package axi_bram_bank_sequencer_pkg;

  localparam logic [7:0] CMD_WR     = 8'h01;
  localparam logic [7:0] CMD_RD     = 8'h02;
  localparam logic [7:0] CMD_DUPLEX = 8'h03;

  localparam logic [1:0] STATUS_OK        = 2'd0;
  localparam logic [1:0] STATUS_RANGE_ERR = 2'd1;
  localparam logic [1:0] STATUS_ABORTED   = 2'd2;
  localparam logic [1:0] STATUS_BAD_CODE  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN, S_DONE} top_state_t;
  typedef enum logic [1:0] {C_IDLE, C_SETUP, C_RUN, C_FIN} chan_state_t;

  // A bank range is unusable if reversed, past the last bank, or carrying no words.
  function automatic logic range_bad(input int first, input int last, input int banks,
                                     input logic cnt_zero);
    return (last < first) || (last >= banks) || cnt_zero;
  endfunction

endpackage

// File: rtl/axi_bram_bank_sequencer_chan.sv
// Per-channel bank stepper: walks idx from bank_start to bank_end, one SETUP/RUN pass per bank.
module bank_channel_seq
  import axi_bram_bank_sequencer_pkg::*;
#(
  parameter int BANKS  = 16,
  parameter int ADDR_W = 16,
  localparam int IDX_W = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              launch,
  input  logic              clear,
  input  logic [IDX_W-1:0]  bank_start,
  input  logic [IDX_W-1:0]  bank_end,
  input  logic [ADDR_W-1:0] addr_start,
  input  logic [ADDR_W-1:0] addr_count,
  input  logic              en_gate,
  input  logic              cnt_done,
  output logic              cnt_start,
  output logic              cnt_en,
  output logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] cnt_limit,
  output logic [IDX_W-1:0]  sel,
  output logic              fin
);

  chan_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= C_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // clear (abort or release by the top FSM) overrides any pending cnt_done.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (clear) begin
      state_d = C_IDLE;
    end else begin
      case (state_q)
        C_IDLE: begin
          if (launch) begin
            state_d = C_SETUP;
            idx_d   = bank_start;
          end
        end
        C_SETUP: state_d = C_RUN;
        C_RUN: begin
          if (cnt_done) begin
            if (idx_q < bank_end) begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = C_SETUP;
            end else begin
              state_d = C_FIN;
            end
          end
        end
        C_FIN:   state_d = C_FIN;
        default: state_d = C_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_start  = 1'b0;
    cnt_en     = 1'b0;
    start_addr = '0;
    cnt_limit  = '0;
    sel        = '0;
    fin        = 1'b0;
    case (state_q)
      C_SETUP: begin
        cnt_start  = 1'b1;
        sel        = idx_q;
        start_addr = addr_start;
        cnt_limit  = addr_count;
      end
      C_RUN: begin
        cnt_en     = en_gate && !cnt_done;
        sel        = idx_q;
        start_addr = addr_start;
        cnt_limit  = addr_count;
      end
      C_FIN:   fin = 1'b1;
      default: fin = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi_bram_bank_sequencer.sv
// BRAM bank sequencer top: command latch, range/code validator and top FSM driving two channels.
module axi_bram_bank_sequencer
  import axi_bram_bank_sequencer_pkg::*;
#(
  parameter int WR_BANKS = 16,
  parameter int RD_BANKS = 8,
  parameter int ADDR_W   = 16,
  localparam int WIDX_W  = (WR_BANKS > 1) ? $clog2(WR_BANKS) : 1,
  localparam int RIDX_W  = (RD_BANKS > 1) ? $clog2(RD_BANKS) : 1
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_code,
  input  logic [WIDX_W-1:0] wr_bank_start,
  input  logic [WIDX_W-1:0] wr_bank_end,
  input  logic [ADDR_W-1:0] wr_addr_start,
  input  logic [ADDR_W-1:0] wr_addr_count,
  input  logic [RIDX_W-1:0] rd_bank_start,
  input  logic [RIDX_W-1:0] rd_bank_end,
  input  logic [ADDR_W-1:0] rd_addr_start,
  input  logic [ADDR_W-1:0] rd_addr_count,
  input  logic              abort,
  input  logic              bram_wr_valid,
  input  logic              wr_cnt_done,
  input  logic              rd_cnt_done,
  output logic              wr_cnt_start,
  output logic              wr_cnt_en,
  output logic [ADDR_W-1:0] wr_start_addr,
  output logic [ADDR_W-1:0] wr_cnt_limit,
  output logic              rd_cnt_start,
  output logic              rd_cnt_en,
  output logic [ADDR_W-1:0] rd_start_addr,
  output logic [ADDR_W-1:0] rd_cnt_limit,
  output logic              bram_rd_en,
  output logic [WIDX_W-1:0] demux_sel,
  output logic [RIDX_W-1:0] mux_sel,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status
);

  top_state_t        state_q, state_d;
  logic [1:0]        status_q, status_d;
  logic [7:0]        code_q, code_d;
  logic [WIDX_W-1:0] wr_bs_q, wr_bs_d, wr_be_q, wr_be_d;
  logic [ADDR_W-1:0] wr_as_q, wr_as_d, wr_ac_q, wr_ac_d;
  logic [RIDX_W-1:0] rd_bs_q, rd_bs_d, rd_be_q, rd_be_d;
  logic [ADDR_W-1:0] rd_as_q, rd_as_d, rd_ac_q, rd_ac_d;

  logic wr_en_s, rd_en_s, code_ok_s, wr_bad_s, rd_bad_s;
  logic launch_s, clear_s, wr_fin_s, rd_fin_s, rd_cnt_en_s;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= S_IDLE;
      status_q <= STATUS_OK;
      code_q   <= 8'h00;
      wr_bs_q  <= '0;
      wr_be_q  <= '0;
      wr_as_q  <= '0;
      wr_ac_q  <= '0;
      rd_bs_q  <= '0;
      rd_be_q  <= '0;
      rd_as_q  <= '0;
      rd_ac_q  <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      code_q   <= code_d;
      wr_bs_q  <= wr_bs_d;
      wr_be_q  <= wr_be_d;
      wr_as_q  <= wr_as_d;
      wr_ac_q  <= wr_ac_d;
      rd_bs_q  <= rd_bs_d;
      rd_be_q  <= rd_be_d;
      rd_as_q  <= rd_as_d;
      rd_ac_q  <= rd_ac_d;
    end
  end

  always_comb begin
    wr_en_s   = (code_q == CMD_WR) || (code_q == CMD_DUPLEX);
    rd_en_s   = (code_q == CMD_RD) || (code_q == CMD_DUPLEX);
    code_ok_s = wr_en_s || rd_en_s;
    wr_bad_s  = wr_en_s && range_bad(int'(wr_bs_q), int'(wr_be_q), WR_BANKS, wr_ac_q == '0);
    rd_bad_s  = rd_en_s && range_bad(int'(rd_bs_q), int'(rd_be_q), RD_BANKS, rd_ac_q == '0);
  end

  // Abort wins over validation and over channel completion in CHECK and RUN.
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    code_d   = code_q;
    wr_bs_d  = wr_bs_q;
    wr_be_d  = wr_be_q;
    wr_as_d  = wr_as_q;
    wr_ac_d  = wr_ac_q;
    rd_bs_d  = rd_bs_q;
    rd_be_d  = rd_be_q;
    rd_as_d  = rd_as_q;
    rd_ac_d  = rd_ac_q;
    launch_s = 1'b0;
    clear_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_CHECK;
          code_d  = cmd_code;
          wr_bs_d = wr_bank_start;
          wr_be_d = wr_bank_end;
          wr_as_d = wr_addr_start;
          wr_ac_d = wr_addr_count;
          rd_bs_d = rd_bank_start;
          rd_be_d = rd_bank_end;
          rd_as_d = rd_addr_start;
          rd_ac_d = rd_addr_count;
        end
      end
      S_CHECK: begin
        if (abort) begin
          state_d  = S_DONE;
          status_d = STATUS_ABORTED;
          clear_s  = 1'b1;
        end else if (!code_ok_s) begin
          state_d  = S_DONE;
          status_d = STATUS_BAD_CODE;
        end else if (wr_bad_s || rd_bad_s) begin
          state_d  = S_DONE;
          status_d = STATUS_RANGE_ERR;
        end else begin
          state_d  = S_RUN;
          status_d = STATUS_OK;
          launch_s = 1'b1;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d  = S_DONE;
          status_d = STATUS_ABORTED;
          clear_s  = 1'b1;
        end else if ((!wr_en_s || wr_fin_s) && (!rd_en_s || rd_fin_s)) begin
          state_d  = S_DONE;
          clear_s  = 1'b1;
        end else begin
          state_d  = S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    status    = done ? status_q : STATUS_OK;
  end

  bank_channel_seq #(.BANKS(WR_BANKS), .ADDR_W(ADDR_W)) u_wr_chan (
    .clk        (aclk),
    .rst        (areset),
    .launch     (launch_s && wr_en_s),
    .clear      (clear_s),
    .bank_start (wr_bs_q),
    .bank_end   (wr_be_q),
    .addr_start (wr_as_q),
    .addr_count (wr_ac_q),
    .en_gate    (bram_wr_valid),
    .cnt_done   (wr_cnt_done),
    .cnt_start  (wr_cnt_start),
    .cnt_en     (wr_cnt_en),
    .start_addr (wr_start_addr),
    .cnt_limit  (wr_cnt_limit),
    .sel        (demux_sel),
    .fin        (wr_fin_s)
  );

  bank_channel_seq #(.BANKS(RD_BANKS), .ADDR_W(ADDR_W)) u_rd_chan (
    .clk        (aclk),
    .rst        (areset),
    .launch     (launch_s && rd_en_s),
    .clear      (clear_s),
    .bank_start (rd_bs_q),
    .bank_end   (rd_be_q),
    .addr_start (rd_as_q),
    .addr_count (rd_ac_q),
    .en_gate    (1'b1),
    .cnt_done   (rd_cnt_done),
    .cnt_start  (rd_cnt_start),
    .cnt_en     (rd_cnt_en_s),
    .start_addr (rd_start_addr),
    .cnt_limit  (rd_cnt_limit),
    .sel        (mux_sel),
    .fin        (rd_fin_s)
  );

  assign rd_cnt_en  = rd_cnt_en_s;
  assign bram_rd_en = rd_cnt_en_s;

endmodule

// File: tb/tb_axi_bram_bank_sequencer.sv
// Directed self-checking bench for axi_bram_bank_sequencer with hand-computed expectations.
module tb_axi_bram_bank_sequencer;

  logic        aclk, areset;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_code;
  logic [3:0]  wr_bank_start, wr_bank_end;
  logic [15:0] wr_addr_start, wr_addr_count;
  logic [2:0]  rd_bank_start, rd_bank_end;
  logic [15:0] rd_addr_start, rd_addr_count;
  logic        abort, bram_wr_valid, wr_cnt_done, rd_cnt_done;
  logic        wr_cnt_start, wr_cnt_en, rd_cnt_start, rd_cnt_en, bram_rd_en;
  logic [15:0] wr_start_addr, wr_cnt_limit, rd_start_addr, rd_cnt_limit;
  logic [3:0]  demux_sel;
  logic [2:0]  mux_sel;
  logic        busy, done;
  logic [1:0]  status;

  int checks = 0;
  int errors = 0;
  int cnt;

  axi_bram_bank_sequencer dut (
    .aclk(aclk), .areset(areset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_code(cmd_code), .wr_bank_start(wr_bank_start), .wr_bank_end(wr_bank_end),
    .wr_addr_start(wr_addr_start), .wr_addr_count(wr_addr_count),
    .rd_bank_start(rd_bank_start), .rd_bank_end(rd_bank_end),
    .rd_addr_start(rd_addr_start), .rd_addr_count(rd_addr_count),
    .abort(abort), .bram_wr_valid(bram_wr_valid), .wr_cnt_done(wr_cnt_done),
    .rd_cnt_done(rd_cnt_done), .wr_cnt_start(wr_cnt_start), .wr_cnt_en(wr_cnt_en),
    .wr_start_addr(wr_start_addr), .wr_cnt_limit(wr_cnt_limit),
    .rd_cnt_start(rd_cnt_start), .rd_cnt_en(rd_cnt_en), .rd_start_addr(rd_start_addr),
    .rd_cnt_limit(rd_cnt_limit), .bram_rd_en(bram_rd_en), .demux_sel(demux_sel),
    .mux_sel(mux_sel), .busy(busy), .done(done), .status(status)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Present a command for one cycle, then sit in CHECK with cmd_valid low.
  task automatic issue(input logic [7:0] code);
    step();
    cmd_valid = 1'b1;
    cmd_code  = code;
    #1;
    chk("accept_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    #1;
    chk("check_busy", busy, 1);
    chk("check_no_start", wr_cnt_start | rd_cnt_start, 0);
  endtask

  initial begin
    areset = 1'b1; cmd_valid = 1'b0; cmd_code = 8'h00;
    wr_bank_start = 4'd0; wr_bank_end = 4'd0; wr_addr_start = 16'h0000; wr_addr_count = 16'h0000;
    rd_bank_start = 3'd0; rd_bank_end = 3'd0; rd_addr_start = 16'h0000; rd_addr_count = 16'h0000;
    abort = 1'b0; bram_wr_valid = 1'b0; wr_cnt_done = 1'b0; rd_cnt_done = 1'b0;
    #12;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done_status", {done, status}, 0);
    chk("rst_outs", {wr_cnt_start, wr_cnt_en, rd_cnt_start, bram_rd_en, demux_sel, mux_sel}, 0);
    @(negedge aclk);
    areset = 1'b0;

    // WRITE banks 2..4
    wr_bank_start = 4'd2; wr_bank_end = 4'd4; wr_addr_start = 16'h0010; wr_addr_count = 16'd8;
    bram_wr_valid = 1'b1;
    issue(8'h01);
    cnt = 0;
    for (int b = 2; b <= 4; b++) begin
      step(); wr_cnt_done = 1'b0; #1;
      cnt += int'(wr_cnt_start);
      chk("wr_setup_start", wr_cnt_start, 1);
      chk("wr_setup_sel", demux_sel, b);
      chk("wr_setup_addr", {wr_start_addr, wr_cnt_limit}, {16'h0010, 16'd8});
      step(); #1;
      cnt += int'(wr_cnt_start);
      chk("wr_run_en", wr_cnt_en, 1);
      chk("wr_run_sel", demux_sel, b);
      step(); wr_cnt_done = 1'b1; #1;
      cnt += int'(wr_cnt_start);
      chk("wr_run_en_at_done", wr_cnt_en, 0);
    end
    step(); wr_cnt_done = 1'b0; #1;
    cnt += int'(wr_cnt_start);
    chk("wr_fin_quiet", {done, wr_cnt_en, demux_sel}, 0);
    chk("wr_start_pulses", cnt, 3);
    step(); #1;
    chk("wr_done", {done, status}, {1'b1, 2'd0});
    step(); #1;
    chk("wr_back_idle", {cmd_ready, done}, {1'b1, 1'b0});

    // READ bank 5..5, 4 words
    rd_bank_start = 3'd5; rd_bank_end = 3'd5; rd_addr_start = 16'h0100; rd_addr_count = 16'd4;
    bram_wr_valid = 1'b0;
    issue(8'h02);
    step(); #1;
    chk("rd_setup", {rd_cnt_start, mux_sel, bram_rd_en}, {1'b1, 3'd5, 1'b0});
    chk("rd_setup_addr", {rd_start_addr, rd_cnt_limit}, {16'h0100, 16'd4});
    chk("rd_no_wr", {wr_cnt_start, demux_sel}, 0);
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      chk("rd_run_en", {bram_rd_en, rd_cnt_en, mux_sel, rd_cnt_start}, {1'b1, 1'b1, 3'd5, 1'b0});
    end
    step(); rd_cnt_done = 1'b1; #1;
    chk("rd_en_at_done", bram_rd_en, 0);
    step(); rd_cnt_done = 1'b0; #1;
    chk("rd_fin_quiet", {done, mux_sel, rd_cnt_start}, 0);
    step(); #1;
    chk("rd_done", {done, status}, {1'b1, 2'd0});
    step(); #1;
    chk("rd_back_idle", cmd_ready, 1);

    // DUPLEX write 0..3, read 0..0: read finishes first and waits
    wr_bank_start = 4'd0; wr_bank_end = 4'd3; wr_addr_count = 16'd2;
    rd_bank_start = 3'd0; rd_bank_end = 3'd0; rd_addr_count = 16'd2;
    bram_wr_valid = 1'b1;
    issue(8'h03);
    step(); #1;
    chk("dx_both_start", {wr_cnt_start, rd_cnt_start}, 2'b11);
    step(); wr_cnt_done = 1'b1; rd_cnt_done = 1'b1; #1;
    cnt = 0;
    for (int b = 1; b <= 3; b++) begin
      step(); wr_cnt_done = 1'b0; rd_cnt_done = 1'b0; #1;
      cnt += int'(done);
      chk("dx_wr_sel", {wr_cnt_start, demux_sel}, {1'b1, 4'(b)});
      chk("dx_rd_idle", {rd_cnt_start, bram_rd_en, mux_sel}, 0);
      step(); wr_cnt_done = 1'b1; rd_cnt_done = 1'b1; #1;
      cnt += int'(done);
    end
    step(); wr_cnt_done = 1'b0; rd_cnt_done = 1'b0; #1;
    cnt += int'(done);
    chk("dx_fin_busy", busy, 1);
    step(); #1;
    cnt += int'(done);
    chk("dx_done", {done, status}, {1'b1, 2'd0});
    step(); #1;
    cnt += int'(done);
    chk("dx_single_done", cnt, 1);

    // Reversed write range
    wr_bank_start = 4'd3; wr_bank_end = 4'd1; wr_addr_count = 16'd8;
    issue(8'h01);
    step(); #1;
    chk("range_rev", {done, status, wr_cnt_start}, {1'b1, 2'd1, 1'b0});
    // Zero word count
    wr_bank_start = 4'd2; wr_bank_end = 4'd2; wr_addr_count = 16'd0;
    issue(8'h01);
    step(); #1;
    chk("range_cnt0", {done, status}, {1'b1, 2'd1});
    // Duplex with good write range but reversed read range
    wr_addr_count = 16'd8; rd_bank_start = 3'd4; rd_bank_end = 3'd2; rd_addr_count = 16'd4;
    issue(8'h03);
    step(); #1;
    chk("range_dx_rd", {done, status}, {1'b1, 2'd1});
    // Unknown code
    issue(8'h07);
    step(); #1;
    chk("bad_code", {done, status}, {1'b1, 2'd3});

    // Abort in IDLE is ignored
    step(); abort = 1'b1; #1;
    step(); abort = 1'b0; #1;
    chk("abort_idle", {busy, done}, 0);

    // Abort on bank 1 of 0..3, coinciding with cnt_done
    wr_bank_start = 4'd0; wr_bank_end = 4'd3; wr_addr_count = 16'd8;
    issue(8'h01);
    step(); #1;
    step(); wr_cnt_done = 1'b1; #1;
    step(); wr_cnt_done = 1'b0; #1;
    chk("ab_bank1", demux_sel, 1);
    step(); #1;
    chk("ab_run_en", wr_cnt_en, 1);
    step(); abort = 1'b1; wr_cnt_done = 1'b1; #1;
    step(); abort = 1'b0; wr_cnt_done = 1'b0; #1;
    chk("ab_done", {done, status}, {1'b1, 2'd2});
    chk("ab_quiet", {wr_cnt_en, wr_cnt_start, demux_sel}, 0);
    step(); #1;
    chk("ab_ready", {cmd_ready, done}, {1'b1, 1'b0});

    // bram_wr_valid toggling gates wr_cnt_en
    wr_bank_start = 4'd6; wr_bank_end = 4'd6;
    issue(8'h01);
    step(); #1;
    for (int i = 0; i < 8; i++) begin
      step(); bram_wr_valid = (i % 2 == 1); #1;
      chk("tog_en", wr_cnt_en, (i % 2 == 1) ? 1 : 0);
    end
    step(); bram_wr_valid = 1'b1; wr_cnt_done = 1'b1; #1;
    chk("tog_en_done", wr_cnt_en, 0);
    step(); wr_cnt_done = 1'b0; #1;
    step(); #1;
    chk("tog_done", {done, status}, {1'b1, 2'd0});

    // areset in RUN
    wr_bank_start = 4'd0; wr_bank_end = 4'd1;
    step(); #1;
    issue(8'h01);
    step(); #1;
    step(); #1;
    chk("rst_run_en", wr_cnt_en, 1);
    #2 areset = 1'b1;
    #1;
    chk("rst_mid_outs", {wr_cnt_en, wr_cnt_start, demux_sel, busy, done}, 0);
    chk("rst_mid_ready", cmd_ready, 1);
    #2 areset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(); #1;
      cnt += int'(done) + int'(busy);
    end
    chk("rst_no_done", cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
